// File: rtl/soi_pkg.sv
// Shared types and constants for the SOI trace transmitter.
package soi_pkg;

    // Tracing FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } trace_state_e;

    localparam int SOI_W_DEF  = 8;
    localparam int TS_W_DEF   = 16;
    localparam int DROP_CNT_W = 8;

    // Record layout at default widths: {soi, ts, ovf}.
    typedef struct packed {
        logic [SOI_W_DEF-1:0] soi;
        logic [TS_W_DEF-1:0]  ts;
        logic                 ovf;
    } soi_rec_t;

endpackage

// File: rtl/soi_rec_fifo.sv
// First-word-fall-through record FIFO. A push into a full FIFO is accepted
// when a pop happens in the same cycle. rdata_o reads as zero while empty.
module soi_rec_fifo #(
    parameter  int DW    = 25,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          accept_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    // Derive full/empty and the effective push/pop for this cycle.
    always_comb begin
        full_o   = (level_q == LW'(DEPTH));
        empty_o  = (level_q == '0);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        accept_o = do_push;
        level_o  = level_q;
        rdata_o  = empty_o ? '0 : mem_q[rd_q];
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

endmodule

// File: rtl/soi_trace_tx.sv
// SOI trace transmitter: records a baseline on arm, then every change or
// trigger of the observed vector with a timestamp, into a drainable FIFO.
// Host handshake: a record transfers on any rising edge where
// rec_valid_o && rec_ready_i; the head stays stable while valid && !ready.
module soi_trace_tx
    import soi_pkg::*;
#(
    parameter  int WIDTH = SOI_W_DEF,
    parameter  int DEPTH = 8,
    parameter  int TS_W  = TS_W_DEF,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      soi_i,
    input  logic                  trig_i,
    output logic                  rec_valid_o,
    input  logic                  rec_ready_i,
    output logic [WIDTH-1:0]      rec_soi_o,
    output logic [TS_W-1:0]       rec_ts_o,
    output logic                  rec_ovf_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o,
    output logic [LW-1:0]         level_o,
    output trace_state_e          state_o
);

    typedef struct packed {
        logic [WIDTH-1:0] soi;
        logic [TS_W-1:0]  ts;
        logic             ovf;
    } rec_t;

    trace_state_e          state_q, state_d;
    logic [TS_W-1:0]       ts_q, ts_d;
    logic [WIDTH-1:0]      last_q;
    logic                  pend_q;
    logic [DROP_CNT_W-1:0] drop_q;
    logic                  push;
    logic                  accept;
    logic                  full;
    logic                  empty;
    rec_t                  wr_rec;
    rec_t                  rd_rec;

    // Next state, push decision and timestamp next value.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        ts_d    = ts_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ARM;
                    ts_d    = '0;
                end
            end
            ST_ARM: begin
                state_d = enable ? ST_RUN : ST_IDLE;
                push    = enable;
                ts_d    = ts_q + 1'b1;
            end
            ST_RUN: begin
                if (!enable) state_d = ST_IDLE;
                push = enable && ((soi_i != last_q) || trig_i);
                ts_d = ts_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, timestamp, last-sample, overflow flag and drop counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
            last_q  <= '0;
            pend_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            if (state_q != ST_IDLE) last_q <= soi_i;
            if (push && accept) begin
                pend_q <= 1'b0;
            end else if (push) begin
                pend_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + 1'b1;
            end
        end
    end

    // Record being offered to the FIFO this cycle.
    always_comb begin
        wr_rec     = '0;
        wr_rec.soi = soi_i;
        wr_rec.ts  = ts_q;
        wr_rec.ovf = pend_q;
    end

    soi_rec_fifo #(
        .DW    ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .wdata_i  (wr_rec),
        .pop_i    (rec_ready_i),
        .rdata_o  (rd_rec),
        .accept_o (accept),
        .full_o   (full),
        .empty_o  (empty),
        .level_o  (level_o)
    );

    // Output mapping from the FIFO head and status registers.
    always_comb begin
        rec_valid_o = !empty;
        rec_soi_o   = rd_rec.soi;
        rec_ts_o    = rd_rec.ts;
        rec_ovf_o   = rd_rec.ovf;
        drop_cnt_o  = drop_q;
        state_o     = state_q;
    end

endmodule

// File: tb/tb_soi_trace_tx.sv
// Bench for soi_trace_tx with a queue-based reference model.
module tb_soi_trace_tx;
    import soi_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int TSW   = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int RW    = W + TSW + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic [W-1:0]   soi = '0;
    logic           trig = 1'b0;
    logic           ready = 1'b0;
    logic           rec_valid;
    logic [W-1:0]   rec_soi;
    logic [TSW-1:0] rec_ts;
    logic           rec_ovf;
    logic [7:0]     drop_cnt;
    logic [LW-1:0]  level;
    trace_state_e   state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: records as {soi, ts, ovf}.
    logic [RW-1:0] exp_q[$];
    int            streak = 0;   // consecutive enabled cycles before this one
    logic [W-1:0]  prev_soi = '0;
    int            m_drop = 0;
    bit            m_pend = 1'b0;

    soi_trace_tx #(.WIDTH(W), .DEPTH(DEPTH), .TS_W(TSW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .soi_i       (soi),
        .trig_i      (trig),
        .rec_valid_o (rec_valid),
        .rec_ready_i (ready),
        .rec_soi_o   (rec_soi),
        .rec_ts_o    (rec_ts),
        .rec_ovf_o   (rec_ovf),
        .drop_cnt_o  (drop_cnt),
        .level_o     (level),
        .state_o     (state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all DUT outputs with the model's current view.
    task automatic compare_all();
        trace_state_e  es;
        logic [RW-1:0] head;
        es = (streak == 0) ? ST_IDLE : (streak == 1) ? ST_ARM : ST_RUN;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("level", 32'(level), 32'(exp_q.size()));
        check("valid", 32'(rec_valid), 32'(exp_q.size() != 0));
        check("rec_soi", 32'(rec_soi), 32'(head[RW-1 -: W]));
        check("rec_ts", 32'(rec_ts), 32'(head[TSW:1]));
        check("rec_ovf", 32'(rec_ovf), 32'(head[0]));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("state", 32'(state), 32'(es));
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit            do_pop;
        bit            do_push;
        logic [TSW-1:0] ts;
        if (rst) begin
            exp_q.delete();
            streak = 0;
            prev_soi = '0;
            m_drop = 0;
            m_pend = 1'b0;
            return;
        end
        do_pop  = (exp_q.size() != 0) && ready;
        do_push = 1'b0;
        if (enable && streak == 1) do_push = 1'b1;
        else if (enable && streak >= 2) do_push = (soi != prev_soi) || trig;
        ts = TSW'((streak - 1) % (1 << TSW));
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back({soi, ts, m_pend});
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (streak >= 1) prev_soi = soi;
        streak = enable ? streak + 1 : 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        trig = 1'b0;
        ready = 1'b0;
        soi = '0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        do_reset();

        // Constant input: one baseline record only.
        enable = 1'b1;
        repeat (8) cycle();
        check("baseline_level", 32'(level), 32'd1);
        check("baseline_ts", 32'(rec_ts), 32'd0);
        ready = 1'b1;
        repeat (4) cycle();
        check("no_more_records", 32'(level), 32'd0);

        // Change at ts=5 with ready held high.
        do_reset();
        enable = 1'b1;
        ready = 1'b1;
        repeat (6) cycle();
        soi = 8'hA5;
        cycle();
        check("a5_valid", 32'(rec_valid), 32'd1);
        check("a5_soi", 32'(rec_soi), 32'hA5);
        check("a5_ts", 32'(rec_ts), 32'd5);
        repeat (3) cycle();

        // Overflow with ready low, then push on full with pop.
        do_reset();
        enable = 1'b1;
        repeat (2) cycle();
        for (int i = 1; i <= 10; i++) begin
            soi = W'(i);
            cycle();
        end
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_drops", 32'(drop_cnt), 32'd3);
        ready = 1'b1;
        soi = 8'h55;
        cycle();
        check("full_pop_level", 32'(level), 32'd8);
        check("full_pop_drops", 32'(drop_cnt), 32'd3);
        repeat (10) cycle();

        // Trigger duplicates and timestamp wrap.
        soi = 8'h3C;
        cycle();
        trig = 1'b1;
        repeat (20) cycle();
        trig = 1'b0;
        repeat (3) cycle();

        // Reset mid-handshake at level 4.
        do_reset();
        enable = 1'b1;
        repeat (2) cycle();
        for (int i = 0; i < 3; i++) begin
            soi = W'(8'h10 + i);
            cycle();
        end
        check("pre_rst_level", 32'(level), 32'd4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        enable = 1'b0;
        check("post_rst_level", 32'(level), 32'd0);
        check("post_rst_valid", 32'(rec_valid), 32'd0);
        check("post_rst_state", 32'(state), 32'(ST_IDLE));
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            rst    = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 15) != 0);
            soi    = W'($urandom_range(0, 3));
            trig   = ($urandom_range(0, 7) == 0);
            ready  = ($urandom_range(0, 2) != 0);
            cycle();
        end
        rst = 1'b0;
        enable = 1'b0;
        ready = 1'b1;
        repeat (DEPTH + 2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
